// File: rtl/melody_pkg.sv
// Shared constants, state encoding and ROM word layout for the melody sequencer.
package melody_pkg;

  localparam logic [5:0] NOTE_REST = 6'd0;
  localparam logic [5:0] NOTE_END  = 6'd63;
  localparam logic [5:0] NOTE_A4   = 6'd22;
  localparam logic [5:0] NOTE_TOP  = 6'd36;

  localparam int CODE_MSB  = 11;
  localparam int CODE_LSB  = 6;
  localparam int BEATS_MSB = 5;
  localparam int BEATS_LSB = 0;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

  // Codes 1..36 are pitched; everything else except the end marker is a rest.
  function automatic logic is_tone(input logic [5:0] code);
    return (code > NOTE_REST) && (code <= NOTE_TOP);
  endfunction

endpackage

// File: rtl/note_div_lut.sv
// Note code to tone-generator half-period divisor, computed at elaboration for CLK_HZ.
module note_div_lut
  import melody_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic [5:0]  code,
  output logic [19:0] div
);

  localparam real SEMITONE = 1.0594630943592953;

  function automatic logic [19:0] calc_div(input int c);
    real f;
    f = 440.0;
    for (int i = c; i < int'(NOTE_A4); i++) f = f / SEMITONE;
    for (int i = int'(NOTE_A4); i < c; i++) f = f * SEMITONE;
    return 20'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5) - 1);
  endfunction

  logic [19:0] table_div [64];

  for (genvar g = 0; g < 64; g++) begin : g_entry
    localparam logic [19:0] DIV = is_tone(6'(g)) ? calc_div(g) : 20'd0;
    assign table_div[g] = DIV;
  end

  assign div = table_div[code];

endmodule

// File: rtl/melody_sequencer.sv
// Walks the note ROM, holding each note's divisor for its beat count with a muted tail gap.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int ADDR_W      = 6,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [19:0]       note_div,
  output logic              mute,
  output logic              playing,
  output logic              done
);

  localparam int PLAY_W = $clog2(63 * BEAT_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [19:0]         div_n;
  logic                mute_n;
  logic                rest_q, rest_n;
  logic [PLAY_W-1:0]   play_cnt_q, play_cnt_n;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_n;

  logic [5:0]          code;
  logic [5:0]          beats;
  logic [5:0]          beats_eff;
  logic [19:0]         lut_div;
  logic [PLAY_W-1:0]   play_len;
  logic [PLAY_W-1:0]   play_load;

  assign code      = rom_data[CODE_MSB:CODE_LSB];
  assign beats     = rom_data[BEATS_MSB:BEATS_LSB];
  assign beats_eff = (beats == 6'd0) ? 6'd1 : beats;
  // PLAY_W is sized for 63 beats, so the product never truncates.
  assign play_len  = PLAY_W'(beats_eff) * PLAY_W'(BEAT_CYCLES);
  assign play_load = play_len - PLAY_W'(GAP_CYCLES + 1);

  note_div_lut #(.CLK_HZ(CLK_HZ)) u_lut (
    .code (code),
    .div  (lut_div)
  );

  assign playing = (state_q == FETCH) || (state_q == LOAD) ||
                   (state_q == PLAY)  || (state_q == GAP);
  assign done    = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr   <= '0;
      note_div   <= '0;
      mute       <= 1'b1;
      rest_q     <= 1'b1;
      play_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_n;
      rom_addr   <= addr_n;
      note_div   <= div_n;
      mute       <= mute_n;
      rest_q     <= rest_n;
      play_cnt_q <= play_cnt_n;
      gap_cnt_q  <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    addr_n     = rom_addr;
    div_n      = note_div;
    mute_n     = mute;
    rest_n     = rest_q;
    play_cnt_n = play_cnt_q;
    gap_cnt_n  = gap_cnt_q;

    if (stop) begin
      state_n = IDLE;
      addr_n  = '0;
      div_n   = '0;
      mute_n  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          mute_n = 1'b1;
          if (start) begin
            state_n = FETCH;
            addr_n  = '0;
          end
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          if (code == NOTE_END) begin
            if (loop_en) begin
              addr_n  = '0;
              state_n = FETCH;
            end else begin
              div_n   = '0;
              mute_n  = 1'b1;
              state_n = DONE;
            end
          end else begin
            div_n      = lut_div;
            rest_n     = !is_tone(code);
            mute_n     = !is_tone(code);
            play_cnt_n = play_load;
            state_n    = PLAY;
          end
        end
        PLAY: begin
          if (pause) begin
            mute_n = 1'b1;
          end else if (play_cnt_q == '0) begin
            mute_n    = 1'b1;
            gap_cnt_n = GAP_W'(GAP_CYCLES - 1);
            state_n   = GAP;
          end else begin
            mute_n     = rest_q;
            play_cnt_n = play_cnt_q - 1'b1;
          end
        end
        GAP: begin
          mute_n = 1'b1;
          if (!pause) begin
            if (gap_cnt_q == '0) begin
              addr_n  = rom_addr + ADDR_W'(1);
              state_n = FETCH;
            end else begin
              gap_cnt_n = gap_cnt_q - 1'b1;
            end
          end
        end
        DONE: begin
          mute_n  = 1'b1;
          div_n   = '0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed scenarios for melody_sequencer with a short beat and a three-entry song.
module tb_melody_sequencer;

  localparam int ADDR_W = 6;
  localparam logic [19:0] DIV_A4 = 20'd113635;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data = '0;
  logic [19:0]       note_div;
  logic              mute;
  logic              playing;
  logic              done;

  logic [11:0] rom [64];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  melody_sequencer #(
    .CLK_HZ      (100_000_000),
    .ADDR_W      (ADDR_W),
    .BEAT_CYCLES (10),
    .GAP_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note_div (note_div),
    .mute     (mute),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
    for (int i = 0; i < 64; i++) rom[i] = {6'd63, 6'd0};
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== 6'd0 || note_div !== 20'd0 || mute !== 1'b1 || playing !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d div=%0d mute=%0b playing=%0b done=%0b expected 0 0 1 0 0",
               rom_addr, note_div, mute, playing, done);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (playing !== 1'b0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: playing=%0b mute=%0b expected 0 1", playing, mute);
    end
  endtask

  task automatic test_play_and_end();
    int n;
    bit bad;
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (playing !== 1'b1 || rom_addr !== 6'd0) begin
      errors++;
      $display("FAIL fetch_state: playing=%0b addr=%0d expected 1 0", playing, rom_addr);
    end
    step();
    step();
    checks++;
    if (note_div !== DIV_A4) begin
      errors++;
      $display("FAIL a4_div: got %0d expected %0d", note_div, DIV_A4);
    end
    n = 0;
    bad = 0;
    while (mute === 1'b0 && n < 100) begin
      if (note_div !== DIV_A4) bad = 1;
      n++;
      step();
    end
    checks++;
    if (n != 18 || bad) begin
      errors++;
      $display("FAIL a4_unmuted_len: got %0d cycles (div_glitch=%0b) expected 18", n, bad);
    end
    n = 0;
    bad = 0;
    while (rom_addr === 6'd0 && n < 100) begin
      if (mute !== 1'b1) bad = 1;
      n++;
      step();
    end
    checks++;
    if (n != 2 || bad || rom_addr !== 6'd1) begin
      errors++;
      $display("FAIL a4_gap: got %0d muted cycles, addr=%0d expected 2 cycles then addr 1", n, rom_addr);
    end
    step();
    step();
    checks++;
    if (note_div !== 20'd0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL rest_load: div=%0d mute=%0b expected 0 1", note_div, mute);
    end
    n = 0;
    bad = 0;
    while (rom_addr === 6'd1 && n < 100) begin
      if (mute !== 1'b1) bad = 1;
      n++;
      step();
    end
    checks++;
    if (n != 10 || bad) begin
      errors++;
      $display("FAIL rest_len: got %0d cycles (unmuted=%0b) expected 10 muted", n, bad);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n != 2 || playing !== 1'b0 || note_div !== 20'd0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: after %0d cycles playing=%0b div=%0d mute=%0b expected 2 0 0 1",
               n, playing, note_div, mute);
    end
    step();
    checks++;
    if (done !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%0b playing=%0b expected 0 0", done, playing);
    end
  endtask

  task automatic test_loop();
    int n;
    int d0;
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    loop_en = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (rom_addr !== 6'd2 && n < 200) begin
      n++;
      step();
    end
    step();
    step();
    checks++;
    if (rom_addr !== 6'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL loop_restart: addr=%0d playing=%0b expected 0 1", rom_addr, playing);
    end
    step();
    step();
    checks++;
    if (note_div !== DIV_A4 || mute !== 1'b0) begin
      errors++;
      $display("FAIL loop_replay: div=%0d mute=%0b expected %0d 0", note_div, mute, DIV_A4);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL loop_no_done: done pulses=%0d expected 0", done_cnt - d0);
    end
    go_idle();
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int seg;
    int unmuted;
    bit bad;
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    seg = 1;
    unmuted = (mute === 1'b0) ? 1 : 0;
    repeat (5) begin
      step();
      seg++;
      if (mute === 1'b0) unmuted++;
    end
    pause = 1'b1;
    bad = 0;
    repeat (7) begin
      step();
      seg++;
      if (mute !== 1'b1 || note_div !== DIV_A4) bad = 1;
    end
    pause = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL pause_hold: mute=%0b div=%0d expected 1 %0d while paused", mute, note_div, DIV_A4);
    end
    while (rom_addr === 6'd0 && seg < 100) begin
      step();
      if (rom_addr === 6'd0) begin
        seg++;
        if (mute === 1'b0) unmuted++;
      end
    end
    checks++;
    if (seg != 27) begin
      errors++;
      $display("FAIL pause_segment: got %0d cycles expected 27", seg);
    end
    checks++;
    if (unmuted != 18) begin
      errors++;
      $display("FAIL pause_unmuted: got %0d cycles expected 18", unmuted);
    end
    go_idle();
  endtask

  task automatic test_stop();
    int n;
    int d0;
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    checks++;
    if (playing !== 1'b0 || rom_addr !== 6'd0 || mute !== 1'b1 || note_div !== 20'd0 || done_cnt != d0) begin
      errors++;
      $display("FAIL stop_in_play: playing=%0b addr=%0d mute=%0b div=%0d done=%0d expected 0 0 1 0 0",
               playing, rom_addr, mute, note_div, done_cnt - d0);
    end
    step();
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle: playing=%0b expected 0", playing);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (rom_addr !== 6'd1 && n < 100) begin
      n++;
      step();
    end
    repeat (4) step();
    checks++;
    if (rom_addr !== 6'd1) begin
      errors++;
      $display("FAIL stop_precond: addr=%0d expected 1", rom_addr);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (rom_addr !== 6'd0 || playing !== 1'b0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL stop_addr_clear: addr=%0d playing=%0b mute=%0b expected 0 0 1", rom_addr, playing, mute);
    end
  endtask

  task automatic test_async_reset();
    int n;
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n = 0;
    while (mute === 1'b0 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (note_div !== DIV_A4 || playing !== 1'b1) begin
      errors++;
      $display("FAIL gap_precond: div=%0d playing=%0b expected %0d 1", note_div, playing, DIV_A4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 6'd0 || note_div !== 20'd0 || mute !== 1'b1 || playing !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: addr=%0d div=%0d mute=%0b playing=%0b done=%0b expected 0 0 1 0 0",
               rom_addr, note_div, mute, playing, done);
    end
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: playing=%0b expected 0", playing);
    end
  endtask

  task automatic test_zero_beats_high_code();
    int n;
    bit bad;
    load_rom({6'd40, 6'd0}, {6'd22, 6'd0}, {6'd63, 6'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (note_div !== 20'd0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL code40_rest: div=%0d mute=%0b expected 0 1", note_div, mute);
    end
    n = 0;
    bad = 0;
    while (rom_addr === 6'd0 && n < 100) begin
      if (mute !== 1'b1) bad = 1;
      n++;
      step();
    end
    checks++;
    if (n != 10 || bad) begin
      errors++;
      $display("FAIL beats0_rest_len: got %0d cycles (unmuted=%0b) expected 10 muted", n, bad);
    end
    step();
    step();
    checks++;
    if (note_div !== DIV_A4) begin
      errors++;
      $display("FAIL beats0_div: got %0d expected %0d", note_div, DIV_A4);
    end
    n = 0;
    while (mute === 1'b0 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL beats0_tone_len: got %0d unmuted cycles expected 8", n);
    end
    go_idle();
  endtask

  initial begin
    load_rom({6'd22, 6'd2}, {6'd0, 6'd1}, {6'd63, 6'd0});
    test_reset();
    test_play_and_end();
    test_loop();
    test_pause();
    test_stop();
    test_async_reset();
    test_zero_beats_high_code();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
